// File: rtl/sent_rx_frame.sv
// -----------------------------------------------------------------------------
// sent_rx_frame
// SENT (SAE J2716) frame receiver. The asynchronous SENT line is
// synchronised, and the spacing between consecutive falling edges is measured
// in clk cycles and rounded to whole ticks. Each interval is then decoded as
// a sync pulse, a status nibble, six data nibbles, a CRC nibble and an
// optional pause pulse. A frame is published only when its CRC matches.
//
// Parameters
//   TICK_CLKS      clk cycles per SENT tick (2..64)
// Ports
//   clk            sole clock, rising edge
//   reset          asynchronous, active-high reset
//   sent_in        raw SENT line (asynchronous)
//   pause_en       1: a pause pulse follows each CRC nibble
//   data_nibble_rx last decoded data nibble
//   nibble_valid   one-clk pulse when data_nibble_rx updates
//   sync_rx        one-clk pulse when a sync pulse is accepted
//   pause_rx       one-clk pulse when a pause pulse is accepted
//   status_out     status nibble of the last valid frame
//   data_out       six data nibbles of the last valid frame, first in [23:20]
//   frame_valid    one-clk pulse when a frame passes CRC
//   channel_error  one-clk pulse on any frame error
//   error_code     cause of the last error (1 sync, 2 range, 3 CRC,
//                  4 pause, 5 timeout), held until the next error
// -----------------------------------------------------------------------------
module sent_rx_frame #(
   parameter int TICK_CLKS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sent_in,
   input  logic        pause_en,
   output logic [3:0]  data_nibble_rx,
   output logic        nibble_valid,
   output logic        sync_rx,
   output logic        pause_rx,
   output logic [3:0]  status_out,
   output logic [23:0] data_out,
   output logic        frame_valid,
   output logic        channel_error,
   output logic [2:0]  error_code
);

   localparam int RW  = $clog2(TICK_CLKS);
   localparam int RW1 = RW + 1;
   localparam logic [RW-1:0] REM_LAST = RW'(TICK_CLKS - 1);
   localparam logic [RW:0]   HALF_CMP = RW1'(TICK_CLKS);

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_STATUS, S_DATA, S_CRC, S_PAUSE
   } state_e;

   typedef enum logic [2:0] {
      ERR_SYNC = 3'd1, ERR_RANGE = 3'd2, ERR_CRC = 3'd3,
      ERR_PAUSE = 3'd4, ERR_TIMEOUT = 3'd5
   } err_e;

   // One CRC table step: c * x^4 mod (x^4 + x^3 + x^2 + 1).
   function automatic logic [3:0] crc_step(input logic [3:0] c);
      logic [3:0] r;
      case (c)
         4'd0:  r = 4'd0;   4'd1:  r = 4'd13;  4'd2:  r = 4'd7;   4'd3:  r = 4'd10;
         4'd4:  r = 4'd14;  4'd5:  r = 4'd3;   4'd6:  r = 4'd9;   4'd7:  r = 4'd4;
         4'd8:  r = 4'd1;   4'd9:  r = 4'd12;  4'd10: r = 4'd6;   4'd11: r = 4'd11;
         4'd12: r = 4'd15;  4'd13: r = 4'd2;   4'd14: r = 4'd8;   default: r = 4'd5;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------- line sync
   logic line_s1, line_s2, line_prev, fall;

   // NOTE: sequential state always uses non-blocking assignments so every
   // flop samples the values from before this clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_s1   <= 1'b0;
         line_s2   <= 1'b0;
         line_prev <= 1'b0;
      end else begin
         line_s1   <= sent_in;
         line_s2   <= line_s1;
         line_prev <= line_s2;
      end
   end

   assign fall = line_prev & ~line_s2;

   // ---------------------------------------------------------- interval timer
   // rem/ticks together hold the clk count since the last falling edge as
   // ticks*TICK_CLKS + rem, so rounding needs no divider.
   logic [RW-1:0] rem;
   logic [9:0]    ticks, ticks_rnd;
   logic          round_up;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem   <= '0;
         ticks <= '0;
      end else if (fall) begin
         rem   <= RW'(1);
         ticks <= '0;
      end else if (rem == REM_LAST) begin
         rem <= '0;
         if (ticks != 10'd1023) ticks <= ticks + 10'd1;
      end else begin
         rem <= rem + 1'b1;
      end
   end

   assign round_up  = ({rem, 1'b0} >= HALF_CMP);
   assign ticks_rnd = (ticks == 10'd1023) ? ticks : ticks + 10'(round_up);

   logic [3:0] nib;
   logic       nib_ok;
   assign nib    = ticks_rnd[3:0] - 4'd12;
   assign nib_ok = (ticks_rnd >= 10'd12) && (ticks_rnd <= 10'd27);

   // --------------------------------------------------------------- frame FSM
   state_e      state, state_n;
   logic [2:0]  nib_idx, nib_idx_n;
   logic [3:0]  crc, crc_n, status_tmp, status_tmp_n;
   logic [23:0] data_tmp, data_tmp_n;
   logic [3:0]  data_nibble_n, status_out_n;
   logic [23:0] data_out_n;
   logic [2:0]  err_code_n;
   logic        nibble_valid_n, sync_n, pause_n, frame_valid_n, chan_err_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         nib_idx        <= '0;
         crc            <= '0;
         status_tmp     <= '0;
         data_tmp       <= '0;
         data_nibble_rx <= '0;
         nibble_valid   <= 1'b0;
         sync_rx        <= 1'b0;
         pause_rx       <= 1'b0;
         status_out     <= '0;
         data_out       <= '0;
         frame_valid    <= 1'b0;
         channel_error  <= 1'b0;
         error_code     <= '0;
      end else begin
         state          <= state_n;
         nib_idx        <= nib_idx_n;
         crc            <= crc_n;
         status_tmp     <= status_tmp_n;
         data_tmp       <= data_tmp_n;
         data_nibble_rx <= data_nibble_n;
         nibble_valid   <= nibble_valid_n;
         sync_rx        <= sync_n;
         pause_rx       <= pause_n;
         status_out     <= status_out_n;
         data_out       <= data_out_n;
         frame_valid    <= frame_valid_n;
         channel_error  <= chan_err_n;
         error_code     <= err_code_n;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_n        = state;
      nib_idx_n      = nib_idx;
      crc_n          = crc;
      status_tmp_n   = status_tmp;
      data_tmp_n     = data_tmp;
      data_nibble_n  = data_nibble_rx;
      status_out_n   = status_out;
      data_out_n     = data_out;
      err_code_n     = error_code;
      nibble_valid_n = 1'b0;
      sync_n         = 1'b0;
      pause_n        = 1'b0;
      frame_valid_n  = 1'b0;
      chan_err_n     = 1'b0;

      if (fall) begin
         // Every edge restarts the timer, so a rejected interval's closing
         // edge is automatically the start of the next sync candidate.
         case (state)
            S_IDLE: state_n = S_SYNC;
            S_SYNC: begin
               if (ticks_rnd >= 10'd55 && ticks_rnd <= 10'd57) begin
                  sync_n  = 1'b1;
                  crc_n   = 4'b0101;
                  state_n = S_STATUS;
               end else begin
                  chan_err_n = 1'b1;
                  err_code_n = ERR_SYNC;
               end
            end
            S_STATUS, S_DATA, S_CRC: begin
               if (!nib_ok) begin
                  chan_err_n = 1'b1;
                  err_code_n = ERR_RANGE;
                  state_n    = S_SYNC;
               end else if (state == S_STATUS) begin
                  status_tmp_n = nib;
                  nib_idx_n    = '0;
                  state_n      = S_DATA;
               end else if (state == S_DATA) begin
                  data_nibble_n  = nib;
                  nibble_valid_n = 1'b1;
                  data_tmp_n     = {data_tmp[19:0], nib};
                  crc_n          = crc_step(crc) ^ nib;
                  if (nib_idx == 3'd5) state_n = S_CRC;
                  else                 nib_idx_n = nib_idx + 3'd1;
               end else begin
                  if (crc_step(crc) == nib) begin
                     status_out_n  = status_tmp;
                     data_out_n    = data_tmp;
                     frame_valid_n = 1'b1;
                  end else begin
                     chan_err_n = 1'b1;
                     err_code_n = ERR_CRC;
                  end
                  state_n = pause_en ? S_PAUSE : S_SYNC;
               end
            end
            S_PAUSE: begin
               if (ticks_rnd >= 10'd12 && ticks_rnd <= 10'd768) begin
                  pause_n = 1'b1;
               end else begin
                  chan_err_n = 1'b1;
                  err_code_n = ERR_PAUSE;
               end
               state_n = S_SYNC;
            end
            default: state_n = S_IDLE;
         endcase
      end else if (state != S_IDLE && ticks == 10'd800) begin
         // Leaving IDLE-less states here guarantees a single timeout pulse.
         chan_err_n = 1'b1;
         err_code_n = ERR_TIMEOUT;
         state_n    = S_IDLE;
      end
   end

endmodule

// File: tb/tb_sent_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_sent_rx_frame
// Self-checking bench for sent_rx_frame. Each scenario is a list of edge
// intervals (plus optional reset pulses); a reference model derives the
// expected event stream and held outputs from the protocol rules, the driver
// plays the intervals onto sent_in, and a monitor logs every output pulse.
// -----------------------------------------------------------------------------
module tb_sent_rx_frame;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        sent_in;
   logic        pause_en;
   logic [3:0]  data_nibble_rx;
   logic        nibble_valid;
   logic        sync_rx;
   logic        pause_rx;
   logic [3:0]  status_out;
   logic [23:0] data_out;
   logic        frame_valid;
   logic        channel_error;
   logic [2:0]  error_code;

   always #5 clk = ~clk;

   sent_rx_frame #(.TICK_CLKS(T)) dut (
      .clk            (clk),
      .reset          (reset),
      .sent_in        (sent_in),
      .pause_en       (pause_en),
      .data_nibble_rx (data_nibble_rx),
      .nibble_valid   (nibble_valid),
      .sync_rx        (sync_rx),
      .pause_rx       (pause_rx),
      .status_out     (status_out),
      .data_out       (data_out),
      .frame_valid    (frame_valid),
      .channel_error  (channel_error),
      .error_code     (error_code)
   );

   // ------------------------------------------------------------ checking
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Event word: kind in [31:28], payload below.
   // kinds: 1 sync, 2 data nibble, 3 valid frame {status,data}, 4 error code, 5 pause
   function automatic logic [31:0] ev(input int kind, input logic [27:0] p);
      logic [31:0] k;
      k = kind;
      return {k[3:0], p};
   endfunction

   // ------------------------------------------------------------- monitor
   logic [31:0] log_q[$];
   int          both_cnt = 0;

   always @(negedge clk) begin
      if (sync_rx)       log_q.push_back(ev(1, 28'd0));
      if (nibble_valid)  log_q.push_back(ev(2, 28'(data_nibble_rx)));
      if (frame_valid)   log_q.push_back(ev(3, {status_out, data_out}));
      if (channel_error) log_q.push_back(ev(4, 28'(error_code)));
      if (pause_rx)      log_q.push_back(ev(5, 28'd0));
      if (frame_valid && channel_error) both_cnt++;
   end

   // ----------------------------------------------------------- CRC model
   // Multiply by x^4 modulo x^4+x^3+x^2+1 by long division.
   function automatic logic [3:0] mul_x4(input logic [3:0] c);
      logic [7:0] v;
      v = {c, 4'b0000};
      for (int b = 7; b >= 4; b--)
         if (v[b]) v = v ^ (8'h1D << (b - 4));
      return v[3:0];
   endfunction

   function automatic logic [3:0] crc_of(input logic [23:0] d);
      logic [3:0] c;
      c = 4'b0101;
      for (int i = 0; i < 6; i++) c = mul_x4(c) ^ d[23 - 4*i -: 4];
      return mul_x4(c);
   endfunction

   // ----------------------------------------------------------- stimulus
   typedef struct { int kind; int clks; } item_t;   // kind 0: interval, 1: reset pulse
   item_t stim[$];
   int    jit_on = 0;

   task automatic add_iv(input int tk);
      int j;
      j = jit_on ? int'($urandom_range(0, T - 1)) - T/2 : 0;
      stim.push_back('{0, tk*T + j});
   endtask

   task automatic add_reset();
      stim.push_back('{1, 0});
   endtask

   task automatic add_frame(input logic [3:0] st, input logic [23:0] d,
                            input logic [3:0] crc, input int pause_tk);
      add_iv(56);
      add_iv(12 + int'(st));
      for (int i = 0; i < 6; i++) add_iv(12 + int'(d[23 - 4*i -: 4]));
      add_iv(12 + int'(crc));
      if (pause_tk > 0) add_iv(pause_tk);
   endtask

   // ---------------------------------------------------- reference model
   logic [31:0] exp_q[$];
   logic [3:0]  exp_status;
   logic [23:0] exp_data;
   logic [2:0]  exp_err;

   localparam int P_IDLE = -1, P_SYNC = 0, P_STATUS = 1, P_CRC = 8, P_PAUSE = 9;

   task automatic run_model(input logic pen);
      int          pos, tk, len;
      logic [3:0]  st;
      logic [3:0]  nibs [6];
      logic [23:0] word;
      pos = P_SYNC;          // the driver's opening edge leaves idle
      st  = '0;
      foreach (nibs[i]) nibs[i] = '0;
      exp_status = '0; exp_data = '0; exp_err = '0;
      foreach (stim[k]) begin
         if (stim[k].kind == 1) begin
            pos = P_SYNC;    // fresh opening edge after the reset
            exp_status = '0; exp_data = '0; exp_err = '0;
         end else begin
            len = stim[k].clks;
            tk  = (2*len + T) / (2*T);
            if (tk > 1023) tk = 1023;
            if (pos != P_IDLE && len > 800*T) begin
               exp_q.push_back(ev(4, 28'd5)); exp_err = 3'd5; pos = P_IDLE;
            end
            if (pos == P_IDLE) begin
               pos = P_SYNC;
            end else if (pos == P_SYNC) begin
               if (tk >= 55 && tk <= 57) begin
                  exp_q.push_back(ev(1, 28'd0)); pos = P_STATUS;
               end else begin
                  exp_q.push_back(ev(4, 28'd1)); exp_err = 3'd1;
               end
            end else if (pos <= P_CRC) begin
               if (tk < 12 || tk > 27) begin
                  exp_q.push_back(ev(4, 28'd2)); exp_err = 3'd2; pos = P_SYNC;
               end else if (pos == P_STATUS) begin
                  st = 4'(tk - 12); pos++;
               end else if (pos < P_CRC) begin
                  nibs[pos - 2] = 4'(tk - 12);
                  exp_q.push_back(ev(2, 28'(tk - 12)));
                  pos++;
               end else begin
                  word = {nibs[0], nibs[1], nibs[2], nibs[3], nibs[4], nibs[5]};
                  if (crc_of(word) == 4'(tk - 12)) begin
                     exp_q.push_back(ev(3, {st, word}));
                     exp_status = st; exp_data = word;
                  end else begin
                     exp_q.push_back(ev(4, 28'd3)); exp_err = 3'd3;
                  end
                  pos = pen ? P_PAUSE : P_SYNC;
               end
            end else begin
               if (tk >= 12 && tk <= 768) exp_q.push_back(ev(5, 28'd0));
               else begin exp_q.push_back(ev(4, 28'd4)); exp_err = 3'd4; end
               pos = P_SYNC;
            end
         end
      end
   endtask

   // ------------------------------------------------------------- driver
   task automatic drive();
      int low;
      sent_in = 1'b0;                       // opening edge
      foreach (stim[k]) begin
         if (stim[k].kind == 1) begin
            repeat (8) @(negedge clk);
            sent_in = 1'b1;
            repeat (8) @(negedge clk);
            reset = 1'b1;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            repeat (6) @(negedge clk);
            sent_in = 1'b0;
         end else begin
            low = stim[k].clks / 2;
            if (low > 5*T) low = 5*T;
            repeat (low) @(negedge clk);
            sent_in = 1'b1;
            repeat (stim[k].clks - low) @(negedge clk);
            sent_in = 1'b0;
         end
      end
      repeat (5*T) @(negedge clk);
      sent_in = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic run_scenario(input string name, input logic pen);
      int base;
      base = log_q.size();
      exp_q.delete();
      pause_en = pen;
      run_model(pen);
      drive();
      check($sformatf("%s event_count", name), log_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s event[%0d]", name, i),
               (base + i < log_q.size()) ? log_q[base + i] : 32'hFFFF_FFFF, exp_q[i]);
      check($sformatf("%s status_out", name), 32'(status_out), 32'(exp_status));
      check($sformatf("%s data_out", name),   32'(data_out),   32'(exp_data));
      check($sformatf("%s error_code", name), 32'(error_code), 32'(exp_err));
      stim.delete();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // ------------------------------------------------------------- main
   initial begin
      logic [23:0] d;
      logic [3:0]  s, bad;
      logic        pen;
      reset = 1'b1; sent_in = 1'b1; pause_en = 1'b0;
      repeat (4) @(negedge clk);
      check("reset data_out",      32'(data_out),      32'd0);
      check("reset status_out",    32'(status_out),    32'd0);
      check("reset error_code",    32'(error_code),    32'd0);
      check("reset data_nibble",   32'(data_nibble_rx), 32'd0);
      check("reset pulses",        32'({nibble_valid, sync_rx, pause_rx, frame_valid, channel_error}), 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      jit_on = 0;
      add_frame(4'h0, 24'h123456, 4'h2, 0);
      add_frame(4'h0, 24'h123456, 4'h5, 0);
      run_scenario("good_then_bad_crc", 1'b0);

      add_frame(4'h0, 24'h000000, 4'h5, 100);
      add_frame(4'h0, 24'h000000, 4'h5, 0);
      run_scenario("pause_two_frames", 1'b1);

      add_iv(50);
      add_frame(4'h3, 24'hA5C3F0, crc_of(24'hA5C3F0), 0);
      run_scenario("bad_sync_then_frame", 1'b0);

      add_iv(56); add_iv(12 + 7); add_iv(13); add_iv(30);
      add_frame(4'h1, 24'h0F1E2D, crc_of(24'h0F1E2D), 0);
      add_iv(900);
      add_frame(4'h2, 24'h654321, crc_of(24'h654321), 0);
      run_scenario("range_then_timeout", 1'b0);

      add_iv(56); add_iv(12 + 9); add_iv(13); add_iv(14); add_iv(15);
      add_reset();
      add_frame(4'h9, 24'h123456, 4'h2, 0);
      run_scenario("reset_mid_frame", 1'b0);

      jit_on = 1;
      for (int r = 0; r < 4; r++) begin
         pen = 1'($urandom_range(0, 1));
         for (int f = 0; f < 3; f++) begin
            d   = 24'($urandom);
            s   = 4'($urandom);
            bad = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            add_frame(s, d, crc_of(d) ^ bad, pen ? int'($urandom_range(12, 150)) : 0);
         end
         run_scenario($sformatf("random%0d", r), pen);
      end

      check("frame_valid with channel_error", both_cnt, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sent_rx_frame.md
SENT_RX_FRAME -- requirements
Module: sent_rx_frame

Interface
REQ-001 SHALL have parameter TICK_CLKS, default 4, meaning clk cycles per SENT tick (legal values 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all logic sampled on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sent_in  input  1  asynchronous SENT line.
REQ-005 SHALL have port pause_en  input  1  1 means a pause pulse follows the CRC nibble of every frame.
REQ-006 SHALL have port data_nibble_rx  output  4  last decoded data nibble.
REQ-007 SHALL have port nibble_valid  output  1  one-clk pulse when data_nibble_rx updates.
REQ-008 SHALL have port sync_rx  output  1  one-clk pulse when a sync pulse is accepted.
REQ-009 SHALL have port pause_rx  output  1  one-clk pulse when a pause pulse is accepted.
REQ-010 SHALL have port status_out  output  4  status nibble of the last valid frame.
REQ-011 SHALL have port data_out  output  24  six data nibbles of the last valid frame; first nibble in [23:20].
REQ-012 SHALL have port frame_valid  output  1  one-clk pulse when a frame passes CRC.
REQ-013 SHALL have port channel_error  output  1  one-clk pulse on any frame error.
REQ-014 SHALL have port error_code  output  3  cause of the last error, held until the next error: 1 sync length, 2 nibble range, 3 CRC, 4 pause range, 5 timeout.

Function
REQ-015 SHALL pass sent_in through a two-flop synchronizer and detect a falling edge when the second flop is 0 and was 1 on the previous clock.
REQ-016 SHALL measure each interval L in clk cycles between consecutive falling edges and convert it to ticks as round(L/TICK_CLKS), with halves rounding up.
REQ-017 SHALL saturate the tick count at 1023.
REQ-018 SHALL update all outputs on the clock after the detect cycle of the edge that ends an interval.
REQ-019 SHALL implement the states IDLE, SYNC, STATUS, DATA (nibble index 0..5), CRC and PAUSE.
REQ-020 In IDLE, the first falling edge SHALL start an interval and move the FSM to SYNC.
REQ-021 In SYNC, an interval of 55..57 ticks SHALL pulse sync_rx and move to STATUS.
REQ-022 In SYNC, any other interval length SHALL set error code 1 and pulse channel_error, stay in SYNC, and treat the terminating edge as a new sync candidate.
REQ-023 In STATUS, DATA and CRC, nibble value SHALL equal ticks-12 for ticks 12..27.
REQ-024 In STATUS, DATA and CRC, a tick count outside 12..27 SHALL set error code 2, discard the frame and go to SYNC; the terminating edge becomes the sync candidate.
REQ-025 Each data nibble SHALL pulse nibble_valid and update data_nibble_rx; status and CRC nibbles SHALL NOT.
REQ-026 CRC SHALL be computed over the six data nibbles only (status excluded): seed 0101, c = T[c] xor nibble per nibble, then a final c = T[c], with T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5} (poly x^4+x^3+x^2+1).
REQ-027 On a CRC match, status_out and data_out SHALL load and frame_valid SHALL pulse; on a mismatch, those outputs SHALL hold, channel_error SHALL pulse and error_code SHALL be 3.
REQ-028 After CRC, the FSM SHALL go to PAUSE if pause_en=1, otherwise to SYNC; pause_en is sampled at the CRC-ending edge.
REQ-029 In PAUSE, an interval of 12..768 ticks SHALL pulse pause_rx and move to SYNC.
REQ-030 In PAUSE, an interval outside 12..768 ticks SHALL set error code 4 and move to SYNC.
REQ-031 In any state other than IDLE, a tick count reaching 800 with no edge SHALL set error code 5, pulse channel_error once and go to IDLE.
REQ-032 frame_valid and channel_error SHALL never assert in the same cycle.

Reset
REQ-033 While reset=1, the FSM SHALL be in IDLE, all counters and synchronizer flops SHALL be 0, and all outputs SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no pulse of any output.
REQ-035 After reset deasserts, decoding SHALL restart from IDLE.

Verification
REQ-036 Bench SHALL cover: TICK_CLKS=4, pause_en=0, sync of 224 clocks, status 0, data 1,2,3,4,5,6, CRC 2 -> sync_rx pulse, six nibble_valid pulses, frame_valid, data_out=0x123456.
REQ-037 Bench SHALL cover: same stimulus with CRC 5 -> channel_error, error_code=3, data_out unchanged.
REQ-038 Bench SHALL cover: all-zero data with CRC 5, pause_en=1 and a 100-tick pause, followed by a second identical frame -> two frame_valid pulses and one pause_rx pulse between them.
REQ-039 Bench SHALL cover: a 50-tick sync candidate followed by a valid 56-tick sync -> error_code=1, then the next frame decodes correctly.
REQ-040 Bench SHALL cover: a data interval of 30 ticks -> error_code=2 and resynchronisation on the following sync; sent_in held high for 900 ticks -> error_code=5, FSM in IDLE.
REQ-041 Bench SHALL cover: reset pulsed after the third data nibble -> no frame_valid and no channel_error; the next full frame is valid.
